// File: rtl/dnn_pkg.sv
// Shared types and the score comparator for the dnn pipeline stages.
// DNN_ARGMAX_SIGNED_EN selects two's-complement score comparison.
package dnn_pkg;

    localparam int DNN_MAX_W = 64;

    typedef enum logic [1:0] {
        ARGMAX_IDLE = 2'd0,
        ARGMAX_SCAN = 2'd1,
        ARGMAX_HOLD = 2'd2
    } argmax_state_e;

    // Operands arrive zero-extended; w is the real score width.
    function automatic logic score_gt(
        input logic [DNN_MAX_W-1:0] a,
        input logic [DNN_MAX_W-1:0] b,
        input int unsigned          w
    );
`ifdef DNN_ARGMAX_SIGNED_EN
        logic [DNN_MAX_W-1:0] m;
        // Flipping the sign bit maps signed order onto unsigned order.
        m = {{(DNN_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
        return (a ^ m) > (b ^ m);
`else
        return a > b;
`endif
    endfunction

endpackage

// File: rtl/dnn_argmax_out.sv
// Serial argmax over the final dense layer's score vector.
// Build with DNN_ARGMAX_SIGNED_EN for signed scores (unsigned otherwise).
module dnn_argmax_out
    import dnn_pkg::*;
#(
    parameter int BitSize    = 32,
    parameter int NumClasses = 2,
    parameter int IndexWidth = (NumClasses > 1) ? $clog2(NumClasses) : 1
) (
    input  logic                               clk,
    input  logic                               res_n,
    input  logic                               in_valid,
    input  logic [NumClasses-1:0][BitSize-1:0] in_data,
    input  logic                               in_done,
    output logic                               in_ready,
    output logic                               out_valid,
    output logic [IndexWidth-1:0]              out_class,
    output logic [BitSize-1:0]                 out_score,
    input  logic                               out_ready,
    output logic                               out_done
);

    argmax_state_e r_state;
    argmax_state_e w_state_nxt;

    logic [NumClasses-1:0][BitSize-1:0] r_lanes;
    logic [IndexWidth-1:0]              r_scan_idx;
    logic [IndexWidth-1:0]              r_best_idx;
    logic [BitSize-1:0]                 r_best_score;
    logic                               r_valid;
    logic                               r_done;
    logic                               r_done_pend;

    logic               w_cap;
    logic               w_last;
    logic               w_gt;
    logic               w_fire;
    logic [BitSize-1:0] w_lane;

    assign in_ready  = (r_state == ARGMAX_IDLE);
    assign w_cap     = in_valid & in_ready;
    assign w_lane    = r_lanes[r_scan_idx];
    assign w_last    = (r_scan_idx == IndexWidth'(NumClasses - 1));
    assign w_gt      = score_gt(DNN_MAX_W'(w_lane),
                                DNN_MAX_W'(r_best_score),
                                BitSize);
    // End-of-set waits for an idle cycle with no new vector arriving.
    assign w_fire    = in_ready & r_done_pend & ~w_cap;

    assign out_valid = r_valid;
    assign out_class = r_best_idx;
    assign out_score = r_best_score;
    assign out_done  = r_done;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= ARGMAX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARGMAX_IDLE: begin
                if (w_cap) begin
                    w_state_nxt = (NumClasses == 1) ? ARGMAX_HOLD
                                                    : ARGMAX_SCAN;
                end
            end
            ARGMAX_SCAN: begin
                if (w_last) begin
                    w_state_nxt = ARGMAX_HOLD;
                end
            end
            ARGMAX_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ARGMAX_IDLE;
                end
            end
            default: w_state_nxt = ARGMAX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_lanes      <= '0;
            r_scan_idx   <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
            r_done_pend  <= 1'b0;
        end else begin
            r_valid     <= (w_state_nxt == ARGMAX_HOLD);
            r_done      <= w_fire;
            r_done_pend <= in_done | (r_done_pend & ~w_fire);
            if (w_cap) begin
                r_lanes      <= in_data;
                r_best_score <= in_data[0];
                r_best_idx   <= '0;
                r_scan_idx   <= IndexWidth'(1);
            end else if (r_state == ARGMAX_SCAN) begin
                // Strictly greater only, so ties keep the lower index.
                if (w_gt) begin
                    r_best_score <= w_lane;
                    r_best_idx   <= r_scan_idx;
                end
                if (!w_last) begin
                    r_scan_idx <= r_scan_idx + IndexWidth'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dnn_argmax_out.sv
// Directed bench for dnn_argmax_out with 2-lane and 6-lane instances.
// Expected values follow the DNN_ARGMAX_SIGNED_EN build setting.
module tb_dnn_argmax_out;

    logic clk = 1'b0;
    logic res_n = 1'b0;

    logic            a_in_valid = 1'b0;
    logic [1:0][31:0] a_in_data = '0;
    logic            a_in_done = 1'b0;
    logic            a_in_ready;
    logic            a_out_valid;
    logic [0:0]      a_out_class;
    logic [31:0]     a_out_score;
    logic            a_out_ready = 1'b0;
    logic            a_out_done;

    logic            b_in_valid = 1'b0;
    logic [5:0][31:0] b_in_data = '0;
    logic            b_in_done = 1'b0;
    logic            b_in_ready;
    logic            b_out_valid;
    logic [2:0]      b_out_class;
    logic [31:0]     b_out_score;
    logic            b_out_ready = 1'b0;
    logic            b_out_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dnn_argmax_out #(.BitSize(32), .NumClasses(2)) u_dut2 (
        .clk       (clk),
        .res_n     (res_n),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_done   (a_in_done),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_class (a_out_class),
        .out_score (a_out_score),
        .out_ready (a_out_ready),
        .out_done  (a_out_done)
    );

    dnn_argmax_out #(.BitSize(32), .NumClasses(6)) u_dut6 (
        .clk       (clk),
        .res_n     (res_n),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_done   (b_in_done),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_class (b_out_class),
        .out_score (b_out_score),
        .out_ready (b_out_ready),
        .out_done  (b_out_done)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send2(input logic [1:0][31:0] v,
                         input int exp_cls,
                         input logic [31:0] exp_sc);
        int lat;
        a_in_data  = v;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("lat2", 64'(lat), 64'(1));
        chk("cls2", 64'(a_out_class), 64'(exp_cls));
        chk("sc2", 64'(a_out_score), 64'(exp_sc));
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        chk("acc2", 64'(a_out_valid), 64'(0));
    endtask

    task automatic send6(input logic [5:0][31:0] v,
                         input int exp_cls,
                         input logic [31:0] exp_sc);
        int lat;
        b_in_data  = v;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("lat6", 64'(lat), 64'(5));
        chk("cls6", 64'(b_out_class), 64'(exp_cls));
        chk("sc6", 64'(b_out_score), 64'(exp_sc));
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        chk("acc6", 64'(b_out_valid), 64'(0));
    endtask

    initial begin
        logic [1:0][31:0] v2;
        logic [5:0][31:0] v6;

        #2;
        chk("rst_rdy", 64'(a_in_ready), 64'(1));
        chk("rst_vld", 64'(a_out_valid), 64'(0));
        chk("rst_cls", 64'(b_out_class), 64'(0));
        chk("rst_sc", 64'(a_out_score), 64'(0));
        chk("rst_done", 64'(a_out_done), 64'(0));
        step();
        res_n = 1'b1;
        step();

        v2[0] = 32'd5; v2[1] = 32'd9;
        send2(v2, 1, 32'd9);
        v2[0] = 32'hFFFF_FFFF; v2[1] = 32'd1;
`ifdef DNN_ARGMAX_SIGNED_EN
        send2(v2, 1, 32'd1);
`else
        send2(v2, 0, 32'hFFFF_FFFF);
`endif
        v2[0] = 32'd4; v2[1] = 32'd4;
        send2(v2, 0, 32'd4);

        v6[0] = 32'hFFFF_FFFD; v6[1] = 32'd7; v6[2] = 32'd7;
        v6[3] = 32'd2; v6[4] = 32'hFFFF_FFF8; v6[5] = 32'd0;
`ifdef DNN_ARGMAX_SIGNED_EN
        send6(v6, 1, 32'd7);
`else
        send6(v6, 0, 32'hFFFF_FFFD);
`endif
        v6[0] = 32'd3; v6[4] = 32'd1;
        send6(v6, 1, 32'd7);
        v6[0] = 32'd1; v6[1] = 32'd2; v6[2] = 32'd3;
        v6[3] = 32'd4; v6[4] = 32'd5; v6[5] = 32'd9;
        send6(v6, 5, 32'd9);

        // Backpressure in HOLD with a competing vector offered.
        v2[0] = 32'd2; v2[1] = 32'd1;
        a_in_data  = v2;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                v2[0] = 32'd1; v2[1] = 32'd4;
                a_in_data  = v2;
                a_in_valid = 1'b1;
            end
            chk("hold_vld", 64'(a_out_valid), 64'(1));
            chk("hold_cls", 64'(a_out_class), 64'(0));
            chk("hold_sc", 64'(a_out_score), 64'(2));
            chk("hold_rdy", 64'(a_in_ready), 64'(0));
            step();
        end
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        chk("hs_rdy", 64'(a_in_ready), 64'(1));
        chk("hs_vld", 64'(a_out_valid), 64'(0));
        step();
        a_in_valid = 1'b0;
        step();
        chk("nx_vld", 64'(a_out_valid), 64'(1));
        chk("nx_cls", 64'(a_out_class), 64'(1));
        chk("nx_sc", 64'(a_out_score), 64'(4));
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;

        // End-of-set raised during the scan of the last vector.
        v2[0] = 32'd8; v2[1] = 32'd3;
        a_in_data  = v2;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        a_in_done  = 1'b1;
        step();
        a_in_done = 1'b0;
        chk("dn_vld", 64'(a_out_valid), 64'(1));
        chk("dn_early", 64'(a_out_done), 64'(0));
        step();
        chk("dn_hold", 64'(a_out_done), 64'(0));
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        chk("dn_hs", 64'(a_out_done), 64'(0));
        step();
        chk("dn_pulse", 64'(a_out_done), 64'(1));
        step();
        chk("dn_end", 64'(a_out_done), 64'(0));

        a_in_done = 1'b1;
        step();
        a_in_done = 1'b0;
        chk("di_0", 64'(a_out_done), 64'(0));
        step();
        chk("di_1", 64'(a_out_done), 64'(1));
        step();
        chk("di_2", 64'(a_out_done), 64'(0));

        // Reset in the middle of a 6-lane scan.
        v6[0] = 32'd1; v6[1] = 32'd7; v6[2] = 32'd2;
        v6[3] = 32'd3; v6[4] = 32'd4; v6[5] = 32'd5;
        b_in_data  = v6;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        b_in_done  = 1'b1;
        step();
        b_in_done = 1'b0;
        step();
        res_n = 1'b0;
        #1;
        chk("mr_rdy", 64'(b_in_ready), 64'(1));
        chk("mr_vld", 64'(b_out_valid), 64'(0));
        chk("mr_cls", 64'(b_out_class), 64'(0));
        chk("mr_sc", 64'(b_out_score), 64'(0));
        chk("mr_done", 64'(b_out_done), 64'(0));
        step();
        res_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mr_nodn", 64'(b_out_done), 64'(0));
        end
        v6[0] = 32'd6; v6[1] = 32'd6; v6[2] = 32'd1;
        v6[3] = 32'd6; v6[4] = 32'd0; v6[5] = 32'd2;
        send6(v6, 0, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
